narnet_stream_driver: RTL and testbench

- Host-side initiator for the NARNet inference core's sample handshake.
- Buffers host samples in a FIFO and presents each one to the core as x plus a one-cycle x_ready strobe.
- Waits for the core's out_ready strobe, captures y, and returns it to the host over a valid/ready result port.
- Generate mode runs the network free: each prediction is fed back as the next input for N steps.

---
 rtl/narnet_stream_driver.sv | 213 +++++++++++++++++++++
 tb/tb_narnet_stream_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/narnet_stream_driver.sv
// narnet_stream_driver: host-side initiator for the NARNet inference core.
// Host samples are queued in a FIFO. Each sample is presented to the core as
// nn_x together with a one-cycle nn_x_ready strobe. The driver then waits for
// nn_out_ready, captures nn_y and returns it on a valid/ready result port.
// Generate mode feeds each prediction back as the next input for gen_count steps.
//
// Optional macro NARNET_DRV_TIMEOUT_EN: a watchdog on WAIT. When it trips, it
// sets a sticky err_timeout and drops the transaction.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_wr_en/s_wr_data host sample write (S8.6 signed), s_full = FIFO full
//   gen_start/gen_count  start closed-loop generation (count 0 = no-op)
//   nn_enable/nn_x/nn_x_ready  core enable, sample, sample strobe
//   nn_y/nn_out_ready core result and result strobe
//   res_data/res_valid/res_ready  result handshake to host
//   busy              FSM not in IDLE
//   err_timeout       sticky watchdog flag (tied 0 without the macro)
module narnet_stream_driver #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_wr_en,
  input  logic [7:0] s_wr_data,
  output logic       s_full,
  input  logic       gen_start,
  input  logic [7:0] gen_count,
  output logic       nn_enable,
  output logic [7:0] nn_x,
  output logic       nn_x_ready,
  input  logic [7:0] nn_y,
  input  logic       nn_out_ready,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic       err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Reject unusable parameterisations at elaboration time
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT == 0)) begin : g_bad_params
    $error("narnet_stream_driver: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, state_nxt;

  // FIFO storage and pointers
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          fifo_wr, fifo_rd, fifo_empty;

  // Datapath registers and their next values
  logic [7:0] last_y, last_y_nxt;
  logic [7:0] gen_left, gen_left_nxt;
  logic [7:0] nn_x_nxt, res_data_nxt;
  logic       res_valid_nxt;

`ifdef NARNET_DRV_TIMEOUT_EN
  localparam int unsigned WD_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            err_nxt;
`endif

  // s_full is checked first, so a write while full is dropped even if a pop happens
  assign fifo_wr    = s_wr_en && !s_full;
  assign fifo_empty = (count == '0);
  assign count_nxt  = count + CW'(fifo_wr) - CW'(fifo_rd);

  // FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= s_wr_data;
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      s_full <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nxt;
      s_full <= (count_nxt == CW'(DEPTH));
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and datapath next values
  always_comb begin
    state_nxt     = state;
    fifo_rd       = 1'b0;
    nn_x_nxt      = nn_x;
    res_data_nxt  = res_data;
    res_valid_nxt = res_valid;
    last_y_nxt    = last_y;
    gen_left_nxt  = gen_left;
`ifdef NARNET_DRV_TIMEOUT_EN
    wd_nxt        = wd_cnt;
    err_nxt       = err_timeout;
`endif
    case (state)
      IDLE: begin
        // Generation wins over a pending FIFO sample
        if (gen_start && (gen_count != 8'd0)) begin
          gen_left_nxt = gen_count;
          nn_x_nxt     = last_y;
          state_nxt    = ISSUE;
        end else if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          nn_x_nxt  = mem[rd_ptr];
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Any out_ready seen here belongs to a previous transaction
`ifdef NARNET_DRV_TIMEOUT_EN
        wd_nxt = '0;
`endif
        state_nxt = WAIT;
      end
      WAIT: begin
        if (nn_out_ready) begin
          res_data_nxt  = nn_y;
          last_y_nxt    = nn_y;
          res_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end
`ifdef NARNET_DRV_TIMEOUT_EN
        else if (wd_cnt >= WD_W'(TIMEOUT - 1)) begin
          // Watchdog expiry: abandon the transaction and any remaining generation
          err_nxt      = 1'b1;
          gen_left_nxt = 8'd0;
          state_nxt    = IDLE;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
`endif
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          res_valid_nxt = 1'b0;
          if (gen_left != 8'd0) begin
            gen_left_nxt = gen_left - 8'd1;
            if (gen_left != 8'd1) begin
              nn_x_nxt  = last_y;
              state_nxt = ISSUE;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nn_enable  <= 1'b0;
      nn_x       <= 8'd0;
      nn_x_ready <= 1'b0;
      res_data   <= 8'd0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      last_y     <= 8'd0;
      gen_left   <= 8'd0;
    end else begin
      nn_enable  <= 1'b1;
      nn_x       <= nn_x_nxt;
      nn_x_ready <= (state_nxt == ISSUE);
      res_data   <= res_data_nxt;
      res_valid  <= res_valid_nxt;
      busy       <= (state_nxt != IDLE);
      last_y     <= last_y_nxt;
      gen_left   <= gen_left_nxt;
    end
  end

`ifdef NARNET_DRV_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= wd_nxt;
      err_timeout <= err_nxt;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_narnet_stream_driver.sv
// Self-checking bench for narnet_stream_driver: a core model answers y = x + 1
// a programmable number of cycles after nn_x_ready. The bench checks stream
// vectors from a table, generate mode, priority, backpressure and reset.
// The watchdog is exercised when NARNET_DRV_TIMEOUT_EN is defined.
module tb_narnet_stream_driver;

`ifdef NARNET_DRV_TIMEOUT_EN
  localparam int unsigned TB_TO = 20;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic       clk, rst;
  logic       s_wr_en;
  logic [7:0] s_wr_data;
  logic       s_full;
  logic       gen_start;
  logic [7:0] gen_count;
  logic       nn_enable;
  logic [7:0] nn_x;
  logic       nn_x_ready;
  logic [7:0] nn_y;
  logic       nn_out_ready;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;

  narnet_stream_driver #(.DEPTH(16), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .s_wr_en(s_wr_en), .s_wr_data(s_wr_data), .s_full(s_full),
    .gen_start(gen_start), .gen_count(gen_count),
    .nn_enable(nn_enable), .nn_x(nn_x), .nn_x_ready(nn_x_ready),
    .nn_y(nn_y), .nn_out_ready(nn_out_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: y = x + 1, out_ready pulses core_lat cycles after x_ready
  int core_lat = 30;
  bit core_en  = 1'b1;
  bit core_pend;
  int core_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_pend    <= 1'b0;
      core_cnt     <= 0;
      nn_out_ready <= 1'b0;
      nn_y         <= 8'd0;
    end else begin
      nn_out_ready <= 1'b0;
      if (nn_x_ready && core_en) begin
        nn_y <= nn_x + 8'd1;
        if (core_lat <= 1) nn_out_ready <= 1'b1;
        else begin
          core_pend <= 1'b1;
          core_cnt  <= 1;
        end
      end else if (core_pend) begin
        if (core_cnt >= core_lat - 1) begin
          nn_out_ready <= 1'b1;
          core_pend    <= 1'b0;
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_sample(input logic [7:0] x);
    s_wr_en   = 1'b1;
    s_wr_data = x;
    @(negedge clk);
    s_wr_en   = 1'b0;
  endtask

  task automatic wait_xready(input int budget);
    int n = 0;
    while (!nn_x_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("xready_wait", 32'(nn_x_ready), 32'd1);
  endtask

  // One stream transaction from an idle, empty driver
  task automatic do_stream(input logic [7:0] x, input int lat, input logic [7:0] y_exp);
    int n;
    core_lat  = lat;
    res_ready = 1'b0;
    write_sample(x);
    check("xready_t1", 32'(nn_x_ready), 32'd0);
    @(negedge clk);
    check("xready_t2", 32'(nn_x_ready), 32'd1);
    check("nn_x", 32'(nn_x), 32'(x));
    check("busy_issue", 32'(busy), 32'd1);
    n = 0;
    while (!res_valid && n < lat + 100) begin
      @(negedge clk);
      n++;
    end
    check("res_latency", 32'(n), 32'(lat + 1));
    check("res_data", 32'(res_data), 32'(y_exp));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_clr", 32'(res_valid), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
  endtask

  // Record issued samples and delivered results until n_res results and idle
  logic [7:0] xs [32];
  logic [7:0] rs [32];
  task automatic collect(input int n_res, input int budget, output int nx, output int nr);
    nx = 0;
    nr = 0;
    for (int c = 0; c < budget; c++) begin
      if (nn_x_ready) begin
        if (nx < 32) xs[nx] = nn_x;
        nx++;
      end
      if (res_valid && res_ready) begin
        if (nr < 32) rs[nr] = res_data;
        nr++;
      end
      if (nr >= n_res && !busy) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] x;
    int         lat;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int nx, nr, n, seen;
    vecs[0] = '{8'h18, 30, 8'h19};
    vecs[1] = '{8'h7F, 5,  8'h80};
    vecs[2] = '{8'hFF, 1,  8'h00};
    vecs[3] = '{8'h80, 2,  8'h81};
    vecs[4] = '{8'h00, 3,  8'h01};

    rst = 1'b1; s_wr_en = 1'b0; s_wr_data = 8'd0;
    gen_start = 1'b0; gen_count = 8'd0; res_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_nn_enable", 32'(nn_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_full", 32'(s_full), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_nn_x", 32'(nn_x), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("nn_enable_rise", 32'(nn_enable), 32'd1);

    // Table-driven stream transactions
    for (int i = 0; i < 5; i++) do_stream(vecs[i].x, vecs[i].lat, vecs[i].y);

    // Generate mode seeded by a stream result of 0x19
    do_stream(8'h18, 30, 8'h19);
    res_ready = 1'b1;
    gen_count = 8'd3; gen_start = 1'b1;
    @(negedge clk);
    gen_start = 1'b0;
    collect(3, 400, nx, nr);
    check("gen_nx", 32'(nx), 32'd3);
    check("gen_nr", 32'(nr), 32'd3);
    check("gen_x0", 32'(xs[0]), 32'h19);
    check("gen_x1", 32'(xs[1]), 32'h1A);
    check("gen_x2", 32'(xs[2]), 32'h1B);
    check("gen_r0", 32'(rs[0]), 32'h1A);
    check("gen_r1", 32'(rs[1]), 32'h1B);
    check("gen_r2", 32'(rs[2]), 32'h1C);
    check("gen_busy_end", 32'(busy), 32'd0);

    // gen_count = 0 is a no-op; the FIFO head is issued instead
    write_sample(8'h30);
    gen_start = 1'b1; gen_count = 8'd0;
    @(negedge clk);
    gen_start = 1'b0;
    collect(1, 200, nx, nr);
    check("zero_nx", 32'(nx), 32'd1);
    check("zero_x0", 32'(xs[0]), 32'h30);
    check("zero_r0", 32'(rs[0]), 32'h31);

    // Generation takes priority over a non-empty FIFO
    write_sample(8'h40);
    gen_start = 1'b1; gen_count = 8'd2;
    @(negedge clk);
    gen_start = 1'b0;
    collect(3, 400, nx, nr);
    check("prio_nx", 32'(nx), 32'd3);
    check("prio_x0", 32'(xs[0]), 32'h31);
    check("prio_x1", 32'(xs[1]), 32'h32);
    check("prio_x2", 32'(xs[2]), 32'h40);
    check("prio_r0", 32'(rs[0]), 32'h32);
    check("prio_r1", 32'(rs[1]), 32'h33);
    check("prio_r2", 32'(rs[2]), 32'h41);

    // FIFO fill under result backpressure
    res_ready = 1'b0;
    core_lat  = 30;
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) check("full_before_17", 32'(s_full), 32'd0);
      s_wr_en = 1'b1; s_wr_data = 8'(i);
      @(negedge clk);
    end
    check("full_after_17", 32'(s_full), 32'd1);
    s_wr_data = 8'h55;
    @(negedge clk);
    s_wr_en = 1'b0;
    check("full_hold", 32'(s_full), 32'd1);
    res_ready = 1'b1;
    collect(17, 2000, nx, nr);
    check("bp_nr", 32'(nr), 32'd17);
    check("bp_nx", 32'(nx), 32'd16);
    for (int k = 0; k < 17; k++) check("bp_result", 32'(rs[k]), 32'(k + 2));
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (nn_x_ready || res_valid) seen++;
      @(negedge clk);
    end
    check("bp_no_extra", 32'(seen), 32'd0);
    check("bp_not_full", 32'(s_full), 32'd0);

    // Asynchronous reset in WAIT with a sample still queued
    res_ready = 1'b0;
    s_wr_en = 1'b1; s_wr_data = 8'h22;
    @(negedge clk);
    s_wr_data = 8'h23;
    @(negedge clk);
    s_wr_en = 1'b0;
    wait_xready(10);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_nn_x", 32'(nn_x), 32'd0);
    check("arst_nn_enable", 32'(nn_enable), 32'd0);
    check("arst_res_data", 32'(res_data), 32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_xready", 32'(nn_x_ready), 32'd0);
    check("arst_s_full", 32'(s_full), 32'd0);
    check("arst_err", 32'(err_timeout), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("arst_enable_low", 32'(nn_enable), 32'd0);
    @(negedge clk);
    check("arst_enable_rise", 32'(nn_enable), 32'd1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy || nn_x_ready) seen++;
      @(negedge clk);
    end
    check("arst_fifo_empty", 32'(seen), 32'd0);
    do_stream(8'h05, 30, 8'h06);

`ifdef NARNET_DRV_TIMEOUT_EN
    // Silent core: watchdog drops the transaction and flags the error
    core_en = 1'b0;
    res_ready = 1'b0;
    write_sample(8'h44);
    wait_xready(10);
    n = 0; seen = 0;
    while (busy && n < 200) begin
      if (res_valid) seen = 1;
      @(negedge clk);
      n++;
    end
    check("to_idle", 32'(busy), 32'd0);
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_no_result", 32'(seen), 32'd0);
    core_en = 1'b1;
    do_stream(8'h45, 30, 8'h46);
    check("to_err_sticky", 32'(err_timeout), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
